// File: rtl/pipe_nodatahazards_wb_pkg.sv
// Shared widths and the MEM/WB pipeline bundle used by the write-back stage.
// ID/EX stages import the same widths.
package pipe_nodatahazards_wb_pkg;

    localparam int              DATA_W   = 32;
    localparam int              REG_AW   = 5;
    localparam int              NUM_REGS = 1 << REG_AW;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic [REG_AW-1:0] wn;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem;
    } mem_wb_t;

    function automatic logic [DATA_W-1:0] wb_select(input mem_wb_t r);
        return r.m2reg ? r.mem : r.alu;
    endfunction

endpackage

// File: rtl/pipe_nodatahazards_wb_mem_wb_reg.sv
// MEM/WB pipeline register: five fields captured each rising edge, async clear.
module pipe_nodatahazards_wb_mem_wb_reg
    import pipe_nodatahazards_wb_pkg::*;
(
    input  logic    clk,
    input  logic    clrn,
    input  mem_wb_t d,
    output mem_wb_t q
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/pipe_nodatahazards_wb_regfile.sv
// 32x32 register file, one write port, two read ports with same-cycle
// write-through bypass. Register 0 reads as zero and is never written.
module pipe_nodatahazards_wb_regfile
    import pipe_nodatahazards_wb_pkg::*;
(
    input  logic              clk,
    input  logic              clrn,
    input  logic              we,
    input  logic [REG_AW-1:0] wn,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] rna,
    input  logic [REG_AW-1:0] rnb,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb
);

    localparam int NUM_RP = 2;

    logic [DATA_W-1:0]             rf [NUM_REGS];
    logic [NUM_RP-1:0][REG_AW-1:0] rn;
    logic [NUM_RP-1:0][DATA_W-1:0] q;

    // we is already qualified with wn != 0, so rf[0] stays at its reset value.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (we) begin
            rf[wn] <= wdata;
        end
    end

    assign rn[0] = rna;
    assign rn[1] = rnb;

    for (genvar g = 0; g < NUM_RP; g++) begin : g_rp
        assign q[g] = (rn[g] == REG_ZERO)    ? '0    :
                      (we && (rn[g] == wn))  ? wdata :
                                               rf[rn[g]];
    end

    assign qa = q[0];
    assign qb = q[1];

endmodule

// File: rtl/pipe_nodatahazards_wb.sv
// Write-back stage: MEM/WB register, ALU/load select, and the bypassed
// register file whose read ports feed ID.
module pipe_nodatahazards_wb
    import pipe_nodatahazards_wb_pkg::*;
(
    input  logic              clk,
    input  logic              clrn,
    input  logic              MEMwreg,
    input  logic              MEMm2reg,
    input  logic [REG_AW-1:0] MEMwn,
    input  logic [DATA_W-1:0] MEMaluResult,
    input  logic [DATA_W-1:0] MEMmemOut,
    input  logic [REG_AW-1:0] rna,
    input  logic [REG_AW-1:0] rnb,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb,
    output logic              WBwreg,
    output logic [REG_AW-1:0] WBwn,
    output logic [DATA_W-1:0] WBwdata
);

    mem_wb_t mem_s, wb_s;
    logic    we;

    assign mem_s = '{wreg:  MEMwreg,
                     m2reg: MEMm2reg,
                     wn:    MEMwn,
                     alu:   MEMaluResult,
                     mem:   MEMmemOut};

    pipe_nodatahazards_wb_mem_wb_reg u_mem_wb (
        .clk  (clk),
        .clrn (clrn),
        .d    (mem_s),
        .q    (wb_s)
    );

    assign WBwreg  = wb_s.wreg;
    assign WBwn    = wb_s.wn;
    assign WBwdata = wb_select(wb_s);
    // A write to r0 is latched for visibility but neither stored nor bypassed.
    assign we      = wb_s.wreg && (wb_s.wn != REG_ZERO);

    pipe_nodatahazards_wb_regfile u_rf (
        .clk   (clk),
        .clrn  (clrn),
        .we    (we),
        .wn    (wb_s.wn),
        .wdata (WBwdata),
        .rna   (rna),
        .rnb   (rnb),
        .qa    (qa),
        .qb    (qb)
    );

endmodule

// File: tb/tb_pipe_nodatahazards_wb.sv
// Bench for the write-back stage: directed scenarios plus random traffic
// against an architectural register-state model.
module tb_pipe_nodatahazards_wb;

    logic        clk = 1'b0;
    logic        clrn;
    logic        MEMwreg, MEMm2reg;
    logic [4:0]  MEMwn, rna, rnb, WBwn;
    logic [31:0] MEMaluResult, MEMmemOut, qa, qb, WBwdata;
    logic        WBwreg;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_nodatahazards_wb dut (
        .clk          (clk),
        .clrn         (clrn),
        .MEMwreg      (MEMwreg),
        .MEMm2reg     (MEMm2reg),
        .MEMwn        (MEMwn),
        .MEMaluResult (MEMaluResult),
        .MEMmemOut    (MEMmemOut),
        .rna          (rna),
        .rnb          (rnb),
        .qa           (qa),
        .qb           (qb),
        .WBwreg       (WBwreg),
        .WBwn         (WBwn),
        .WBwdata      (WBwdata)
    );

    // Model: committed architectural registers plus the one instruction
    // sitting in write-back, whose result is visible to readers immediately.
    logic [31:0] arf [32];
    logic        p_wreg;
    logic [4:0]  p_wn;
    logic [31:0] p_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) arf[i] = '0;
        p_wreg = 1'b0;
        p_wn   = '0;
        p_val  = '0;
    endtask

    function automatic logic [31:0] arch(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (p_wreg && p_wn == r) return p_val;
        return arf[r];
    endfunction

    task automatic drive(input logic w, input logic m, input logic [4:0] n,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [4:0] ra, input logic [4:0] rb);
        MEMwreg = w; MEMm2reg = m; MEMwn = n;
        MEMaluResult = alu; MEMmemOut = mem;
        rna = ra; rnb = rb;
    endtask

    // One rising edge: retire the WB instruction, then move MEM into WB.
    task automatic step();
        @(posedge clk);
        if (!clrn) begin
            model_reset();
        end else begin
            if (p_wreg && p_wn != 5'd0) arf[p_wn] = p_val;
            p_wreg = MEMwreg;
            p_wn   = MEMwn;
            p_val  = MEMm2reg ? MEMmemOut : MEMaluResult;
        end
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".wreg"}, {31'b0, WBwreg}, {31'b0, p_wreg});
        chk({tag, ".wn"},   {27'b0, WBwn},   {27'b0, p_wn});
        chk({tag, ".wdata"}, WBwdata, p_val);
        chk({tag, ".qa"}, qa, arch(rna));
        chk({tag, ".qb"}, qb, arch(rnb));
    endtask

    initial begin
        logic [4:0] ra, rb;
        model_reset();
        clrn = 1'b0;
        drive(1, 0, 5'd5, 32'hCAFE_0005, 32'h0, 5'd5, 5'd5);
        #2;

        // Reset held with a write presented: nothing latched, nothing visible.
        step();
        step();
        #1;
        chk("rst.qa", qa, 32'h0);
        chk("rst.wreg", {31'b0, WBwreg}, 32'h0);
        chk("rst.wdata", WBwdata, 32'h0);
        clrn = 1'b1;
        drive(0, 0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd3);
        check_all("rel");

        // ALU write to r3, bypass then storage.
        drive(1, 0, 5'd3, 32'h1234_5678, 32'h5555_5555, 5'd3, 5'd0);
        step();
        drive(0, 0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd0);
        #1;
        chk("alu.wdata", WBwdata, 32'h1234_5678);
        chk("alu.byp", qa, 32'h1234_5678);
        check_all("alu1");
        step();
        #1;
        chk("alu.stored", qa, 32'h1234_5678);

        // Load write to r7 must take memory data, not the address.
        drive(1, 1, 5'd7, 32'h0000_0040, 32'hDEAD_BEEF, 5'd7, 5'd7);
        step();
        drive(0, 0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd3);
        step();
        #1;
        chk("load.r7", qa, 32'hDEAD_BEEF);
        chk("load.r3", qb, 32'h1234_5678);

        // r0 protection over several cycles.
        drive(1, 0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            chk("r0.qa", qa, 32'h0);
            chk("r0.wreg", {31'b0, WBwreg}, 32'h1);
        end

        // Dual bypass of r9, with r10 written earlier.
        drive(1, 0, 5'd10, 32'h1010_1010, 32'h0, 5'd0, 5'd0);
        step();
        drive(1, 0, 5'd9, 32'hA5A5_A5A5, 32'h0, 5'd9, 5'd9);
        step();
        #1;
        chk("dual.qa", qa, 32'hA5A5_A5A5);
        chk("dual.qb", qb, 32'hA5A5_A5A5);
        rnb = 5'd10;
        #1;
        chk("dual.r10", qb, 32'h1010_1010);

        // Reset between latch and write of a pending r4 write.
        drive(1, 0, 5'd4, 32'h4444_4444, 32'h0, 5'd4, 5'd9);
        step();
        clrn = 1'b0;
        model_reset();
        #1;
        chk("midrst.qa", qa, 32'h0);
        chk("midrst.r9", qb, 32'h0);
        step();
        clrn = 1'b1;
        drive(0, 0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd4);
        step();
        #1;
        chk("midrst.r4", qa, 32'h0);

        // Random traffic, small register window to force collisions.
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? p_wn : 5'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? p_wn : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom, $urandom, ra, rb);
            check_all("rnd");
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
